// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential 32x32 shift-add multiplier among NUM_REQ clients.
// Optional BUSY watchdog is compiled in when MUL_ARB_TIMEOUT_EN is defined.
module mul_share_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NUM_REQ-1:0]    i_req,
   input  logic [NUM_REQ*32-1:0] i_req_a,
   input  logic [NUM_REQ*32-1:0] i_req_b,
   output logic [NUM_REQ-1:0]    o_gnt,
   output logic [NUM_REQ-1:0]    o_rsp_valid,
   output logic [63:0]           o_rsp_product,
   output logic                  o_rsp_err,
   output logic                  o_busy,
   output logic                  o_mul_start,
   output logic [31:0]           o_mul_a,
   output logic [31:0]           o_mul_b,
   input  logic [63:0]           i_mul_product,
   input  logic                  i_mul_finish
);

   typedef enum logic [2:0] {StIdle, StLaunch, StWaitClr, StBusy, StResp} state_e;

   state_e               r_state;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_owner;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [63:0]          r_rsp_product;
   logic                 r_busy;
   logic                 r_mul_start;
   logic [31:0]          r_mul_a;
   logic [31:0]          r_mul_b;

   logic                 w_found;
   logic [IDX_W-1:0]     w_sel;
   logic [IDX_W-1:0]     w_ptr_nxt;
   logic [31:0]          w_a;
   logic [31:0]          w_b;
   logic [NUM_REQ-1:0]   w_gnt;
   logic [NUM_REQ-1:0]   w_owner_oh;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_rsp_err;
   assign o_rsp_err = r_rsp_err;
`else
   assign o_rsp_err = 1'b0 & (TIMEOUT != 0);
`endif

   // First set request at or above the rr pointer, wrapping at NUM_REQ.
   always_comb begin : p_arb
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(r_ptr) + k) % NUM_REQ;
         if (!w_found && i_req[IDX_W'(idx)]) begin
            w_found = 1'b1;
            w_sel   = IDX_W'(idx);
         end
      end
   end

   assign w_ptr_nxt = (32'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;

   always_comb begin
      w_a        = '0;
      w_b        = '0;
      w_gnt      = '0;
      w_owner_oh = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == w_sel) begin
            w_a = i_req_a[k*32 +: 32];
            w_b = i_req_b[k*32 +: 32];
         end
         w_gnt[k]      = i_rst_n && (r_state == StIdle) && w_found && (IDX_W'(k) == w_sel);
         w_owner_oh[k] = (IDX_W'(k) == r_owner);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_ptr         <= '0;
         r_owner       <= '0;
         r_rsp_valid   <= '0;
         r_rsp_product <= '0;
         r_busy        <= 1'b0;
         r_mul_start   <= 1'b0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         r_cnt         <= '0;
         r_rsp_err     <= 1'b0;
`endif
      end else begin
         r_mul_start <= 1'b0;
         r_rsp_valid <= '0;
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_mul_a     <= w_a;
                  r_mul_b     <= w_b;
                  r_owner     <= w_sel;
                  r_ptr       <= w_ptr_nxt;
                  r_mul_start <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= StLaunch;
               end
            end
            StLaunch: r_state <= StWaitClr;
            // Multiplier finish flag is stale here, so it is not looked at.
            StWaitClr: begin
`ifdef MUL_ARB_TIMEOUT_EN
               r_cnt   <= '0;
`endif
               r_state <= StBusy;
            end
            StBusy: begin
               if (i_mul_finish) begin
                  r_rsp_product <= i_mul_product;
                  r_rsp_valid   <= w_owner_oh;
                  r_state       <= StResp;
`ifdef MUL_ARB_TIMEOUT_EN
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_rsp_product <= '0;
                  r_rsp_valid   <= w_owner_oh;
                  r_rsp_err     <= 1'b1;
                  r_state       <= StResp;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
`endif
               end
            end
            StResp: begin
`ifdef MUL_ARB_TIMEOUT_EN
               r_rsp_err <= 1'b0;
`endif
               r_busy    <= 1'b0;
               r_state   <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_gnt         = w_gnt;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_product = r_rsp_product;
   assign o_busy        = r_busy;
   assign o_mul_start   = r_mul_start;
   assign o_mul_a       = r_mul_a;
   assign o_mul_b       = r_mul_b;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed cases then randomized clients,
// checked cycle by cycle against a transaction-level timing/arbitration model.
module tb_mul_share_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned IW  = 2;
   localparam int unsigned TO  = 64;
   localparam int unsigned LAT = 32;
   localparam int          RESP_NORMAL = 35;  // gnt at 0, start 1, finish seen 34, response 35

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic [N-1:0]    gnt, rsp_valid;
   logic [63:0]     rsp_product, mul_product;
   logic            rsp_err, busy, mul_start, mul_finish;
   logic [31:0]     mul_a, mul_b;

   always #5 clk = ~clk;

   mul_share_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req        (req),
      .i_req_a      (req_a),
      .i_req_b      (req_b),
      .o_gnt        (gnt),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_product(rsp_product),
      .o_rsp_err    (rsp_err),
      .o_busy       (busy),
      .o_mul_start  (mul_start),
      .o_mul_a      (mul_a),
      .o_mul_b      (mul_b),
      .i_mul_product(mul_product),
      .i_mul_finish (mul_finish)
   );

   // Behavioural multiplier: finish rises LAT edges after start, stays high until
   // the edge after the next start (so it reads stale in the cycle after start).
   logic [5:0] m_cnt;
   bit         m_hang = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_finish  <= 1'b0;
         mul_product <= '0;
         m_cnt       <= '0;
      end else if (mul_start) begin
         m_cnt       <= 6'(LAT);
         mul_product <= 64'(mul_a) * 64'(mul_b);
      end else if (m_cnt != 0) begin
         m_cnt      <= m_cnt - 1'b1;
         mul_finish <= (m_cnt == 1) && !m_hang;
      end
   end

   // Reference model state
   int              nchk = 0, nerr = 0;
   int              cyc_now = 0, t_gnt = 0, owner = 0, ptr = 0;
   bit              active = 1'b0;
   int              resp_at = RESP_NORMAL;
   logic [31:0]     ea, eb;
   logic [63:0]     last_prod = '0;
   logic [N-1:0]    drop_q = '0;
   bit              hold [N];
   int              gq[$];
   logic [63:0]     pq[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc_now, got, exp);
      end
   endtask

   task automatic step();
      logic [N-1:0] eg, erv;
      int           cyc, sel;
      bit           found;
      eg = '0; erv = '0; found = 1'b0; sel = 0;
      if (active) begin
         cyc = cyc_now - t_gnt;
         check("mul_start", mul_start, cyc == 1);
         check("busy", busy, 1'b1);
         check("mul_a", mul_a, ea);
         check("mul_b", mul_b, eb);
         if (cyc == resp_at) begin
            erv[owner] = 1'b1;
            last_prod  = m_hang ? 64'd0 : 64'(ea) * 64'(eb);
            pq.push_back(rsp_product);
         end
         check("rsp_valid", rsp_valid, erv);
         check("rsp_err", rsp_err, (cyc == resp_at) && m_hang);
         if (cyc == resp_at) active = 1'b0;
      end else begin
         check("mul_start_idle", mul_start, 1'b0);
         check("busy_idle", busy, 1'b0);
         check("rsp_valid_idle", rsp_valid, '0);
         check("rsp_err_idle", rsp_err, 1'b0);
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (!found && req[idx]) begin
               found = 1'b1;
               sel   = idx;
            end
         end
         if (found) begin
            eg[sel]     = 1'b1;
            active      = 1'b1;
            t_gnt       = cyc_now;
            owner       = sel;
            ea          = req_a[sel*32 +: 32];
            eb          = req_b[sel*32 +: 32];
            ptr         = (sel + 1) % N;
            drop_q[sel] = !hold[sel];
            gq.push_back(sel);
         end
      end
      check("gnt", gnt, eg);
      check("rsp_product", rsp_product, last_prod);
      cyc_now++;
   endtask

   // Called at a falling edge after the caller has set this cycle's inputs.
   task automatic cycle();
      req    = req & ~drop_q;
      drop_q = '0;
      #1;
      step();
      @(negedge clk);
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((active || (req != 0)) && n < 400) begin
         cycle();
         n++;
      end
      check("wait_bound", n >= 400, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_gnt", gnt, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_product", rsp_product, '0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_mul_start", mul_start, 1'b0);
      check("rst_mul_a", mul_a, '0);
      check("rst_mul_b", mul_b, '0);
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      active    = 1'b0;
      ptr       = 0;
      last_prod = '0;
      drop_q    = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < N; i++) hold[i] = 1'b0;
      @(negedge clk);
      do_reset();

      // Single request, small operands
      set_op(0, 32'd3, 32'd5);
      req[0] = 1'b1;
      wait_done();
      check("t1_product", rsp_product, 64'd15);

      // All four from reset: order 0,1,2,3 then 0 again
      req = '0;
      do_reset();
      gq.delete(); pq.delete();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd10);
         req = '1;
         wait_done();
      end
      for (int k = 0; k < 5; k++) begin
         check("t2_order", 64'(gq[k]), 64'(k % 4));
         check("t2_product", pq[k], 64'((k % 4 + 1) * 10));
      end

      // Two requesters held continuously alternate
      gq.delete();
      hold[0] = 1'b1; hold[2] = 1'b1;
      set_op(0, 32'd7, 32'd9);
      set_op(2, 32'hDEAD_BEEF, 32'd2);
      req = 4'b0101;
      repeat (4 * 36 + 2) cycle();
      for (int k = 0; k < 4; k++) check("t3_order", 64'(gq[k]), (k % 2 == 0) ? 64'd0 : 64'd2);
      hold[0] = 1'b0; hold[2] = 1'b0;
      req = '0;
      wait_done();

      // Full-width product
      set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      req[1] = 1'b1;
      wait_done();
      check("t4_product", rsp_product, 64'hFFFF_FFFE_0000_0001);

      // Reset ten cycles into BUSY, then a normal transaction
      set_op(2, 32'h1234_5678, 32'h9ABC_DEF0);
      req[2] = 1'b1;
      n = 0;
      while (!(active && (cyc_now - t_gnt) == 13) && n < 100) begin
         cycle();
         n++;
      end
      check("t5_reach_busy", n >= 100, 1'b0);
      req = '0;
      do_reset();
      repeat (40) cycle();
      set_op(3, 32'h0001_0001, 32'hFFFF_0000);
      req[3] = 1'b1;
      wait_done();
      check("t5_product", rsp_product, 64'h0000_FFFF_FFFF_0000);

`ifdef MUL_ARB_TIMEOUT_EN
      // Multiplier never finishes: watchdog response with error
      m_hang  = 1'b1;
      resp_at = 3 + TO;
      set_op(1, 32'd11, 32'd13);
      req[1] = 1'b1;
      wait_done();
      check("t7_product", rsp_product, 64'd0);
      m_hang  = 1'b0;
      resp_at = RESP_NORMAL;
`endif

      // Randomized clients: raise, occasionally abandon, re-request in own RESP cycle
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            bit pending;
            pending = active && (owner == i) && ((cyc_now - t_gnt) < resp_at);
            if (!req[i] && !pending && !drop_q[i] && $urandom_range(0, 2) == 0) begin
               set_op(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
               req[i] = 1'b1;
            end else if (req[i] && !drop_q[i] && $urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;
            end
         end
         cycle();
      end
      req = '0;
      wait_done();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential shift-add 32x32 multiplier (start/finish handshake, ~32-cycle latency) among NUM_REQ requesters.
- Round-robin arbitration, operand capture, and start sequencing.
- Routes the 64-bit product back to the granted requester.
- Sits between client blocks and the single multiplier instance in the arithmetic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, owner index width; must equal clog2(NUM_REQ).
- TIMEOUT, 64, watchdog cycle limit in BUSY. Used only with MUL_ARB_TIMEOUT_EN.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- req, in, NUM_REQ, per-requester level request; held until its gnt bit pulses.
- req_a, in, NUM_REQ*32, multiplicand bus; slice i belongs to requester i.
- req_b, in, NUM_REQ*32, multiplier bus; slice i belongs to requester i.
- gnt, out, NUM_REQ, one-hot single-cycle pulse; marks the cycle operands are captured.
- rsp_valid, out, NUM_REQ, one-hot single-cycle pulse; product valid for that requester.
- rsp_product, out, 64, result; holds value until the next response.
- rsp_err, out, 1, qualifies rsp_valid; 1 = timed out. Constant 0 without MUL_ARB_TIMEOUT_EN.
- busy, out, 1, high in any state other than IDLE.
- mul_start, out, 1, one-cycle start pulse to the multiplier.
- mul_a, out, 32, registered multiplicand; stable from LAUNCH through RESP.
- mul_b, out, 32, registered multiplier; same stability as mul_a.
- mul_product, in, 64, multiplier result.
- mul_finish, in, 1, multiplier done flag. Stale (may read 1) in the cycle after start.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, owner=0.
  - gnt, rsp_valid, rsp_err, busy, mul_start = 0.
  - mul_a, mul_b, rsp_product = 0.
- States: IDLE -> LAUNCH -> WAIT_CLR -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr pointer upward, wrapping at NUM_REQ.
  - Same cycle: gnt[sel]=1 for exactly one cycle, register req_a/req_b slice sel into mul_a/mul_b, owner<=sel, rr pointer<=(sel+1) mod NUM_REQ.
  - Go to LAUNCH.
- LAUNCH: mul_start=1 for this cycle only. Go to WAIT_CLR.
- WAIT_CLR: mul_finish ignored for this one cycle. Go to BUSY.
- BUSY: stay until mul_finish==1. The first cycle it is seen high, register mul_product into rsp_product and go to RESP.
- RESP: rsp_valid[owner]=1 for one cycle, rsp_err as computed. Go to IDLE.
- Latency:
  - gnt at cycle T.
  - mul_start at T+1.
  - rsp_valid one cycle after finish is first sampled in BUSY.
  - Minimum turnaround is 4 cycles plus multiplier latency.
- Requests arriving while busy are not granted. They are arbitrated in the next IDLE cycle.
- A requester dropping req before gnt gets no grant or response.
- A requester may reassert req in its own RESP cycle. It competes in the following IDLE cycle with rr priority already advanced past it.
- Simultaneous req bits in IDLE: only one grant per transaction, never two gnt bits high.
- Products are full 64-bit unsigned, no truncation. Example: 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
- Reset asserted mid-operation: immediate return to reset values, no response issued. The multiplier must share rst.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with mul_finish still 0: rsp_product<=0, go to RESP with rsp_err=1.
  - Finish arriving in the same cycle as the limit takes precedence; rsp_err=0.
- Undefined: no counter logic, rsp_err tied to 0, BUSY waits indefinitely.

Test Plan:
- Bench uses a behavioural multiplier model with 32-cycle finish latency.
- Single req[0], a=3, b=5 -> gnt[0] pulse, mul_start one cycle later, rsp_valid[0] with rsp_product=15, rsp_err=0.
- All four req high from reset with a=i+1, b=10 -> grant order 0,1,2,3 with products 10,20,30,40; a fifth round grants 0 again.
- req[0] and req[2] held continuously -> grants alternate 0,2,0,2; never two gnt bits in one cycle.
- req[1], a=b=0xFFFFFFFF -> rsp_product=0xFFFFFFFE00000001; mul_a/mul_b stable from LAUNCH through RESP.
- rst pulsed low 10 cycles into BUSY -> all outputs 0 immediately, no rsp_valid; after release, a new req[3] completes normally.
- MUL_ARB_TIMEOUT_EN defined, model holds finish=0 -> after 64 BUSY cycles rsp_valid[owner]=1, rsp_err=1, rsp_product=0, then IDLE.
